// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI-Stream source emitting counting-pattern frames with
// programmable length, gap, frame count, tid/tdest and bad-frame tuser marking.
module axis_frame_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16,
    parameter int GAP_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [31:0]           cfg_frame_count,
    input  logic [ID_WIDTH-1:0]   cfg_id,
    input  logic [DEST_WIDTH-1:0] cfg_dest,
    input  logic                  cfg_bad,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_busy,
    output logic                  status_frame_sent,
    output logic [31:0]           status_frames_sent
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t state, state_next;

    logic [LEN_WIDTH-1:0]  last_idx_q;
    logic [LEN_WIDTH-1:0]  beat_idx;
    logic [KEEP_WIDTH-1:0] last_keep_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [31:0]           count_q;
    logic [31:0]           frame_idx;
    logic                  bad_q;
    logic                  stop_seen;

    logic                  accept;
    logic                  stop_pending;
    logic                  do_start;
    logic                  do_step;
    logic                  do_frame_end;
    logic                  do_restart;
    logic                  do_gap_tick;

    logic                  load_en;
    logic                  load_is_last;
    logic                  load_bad;
    logic [7:0]            load_f;
    logic [LEN_WIDTH-1:0]  load_j;
    logic [LEN_WIDTH-1:0]  load_last_idx;
    logic [KEEP_WIDTH-1:0] load_last_keep;
    logic [LEN_WIDTH-1:0]  start_last_idx;
    logic [KEEP_WIDTH-1:0] start_last_keep;

    // Byte lane b of beat j in frame f carries (f + j*KEEP_WIDTH + b) mod 256.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [7:0] f,
                                                      input logic [LEN_WIDTH-1:0] j);
        logic [7:0]            base;
        logic [DATA_WIDTH-1:0] d;
        base = f + 8'(j * LEN_WIDTH'(KEEP_WIDTH));
        for (int b = 0; b < KEEP_WIDTH; b++) begin
            d[b*8 +: 8] = base + 8'(b);
        end
        return d;
    endfunction

    function automatic logic [KEEP_WIDTH-1:0] tail_keep(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0]  rem;
        logic [KEEP_WIDTH-1:0] m;
        rem = (len - LEN_WIDTH'(1)) % LEN_WIDTH'(KEEP_WIDTH);
        for (int b = 0; b < KEEP_WIDTH; b++) begin
            m[b] = KEEP_ENABLE ? (LEN_WIDTH'(b) <= rem) : 1'b1;
        end
        return m;
    endfunction

    assign accept          = m_axis_tvalid && m_axis_tready;
    assign stop_pending    = stop_seen || stop;
    assign status_busy     = (state != IDLE);
    assign start_last_idx  = (cfg_frame_len - LEN_WIDTH'(1)) / LEN_WIDTH'(KEEP_WIDTH);
    assign start_last_keep = tail_keep(cfg_frame_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        do_start     = 1'b0;
        do_step      = 1'b0;
        do_frame_end = 1'b0;
        do_restart   = 1'b0;
        do_gap_tick  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (cfg_frame_len != '0)) begin
                    do_start   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (!m_axis_tlast) begin
                        do_step = 1'b1;
                    end else begin
                        do_frame_end = 1'b1;
                        if (stop_pending ||
                            ((count_q != '0) && (frame_idx + 32'd1 == count_q))) begin
                            state_next = IDLE;
                        end else if (gap_q != '0) begin
                            state_next = GAP;
                        end else begin
                            do_restart = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_WIDTH'(1)) begin
                    if (stop_pending) begin
                        state_next = IDLE;
                    end else begin
                        do_restart = 1'b1;
                        state_next = SEND;
                    end
                end else begin
                    do_gap_tick = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame index is bumped on the last accept, so a direct SEND->SEND restart
    // must look one frame ahead while a restart out of GAP uses it as is.
    always_comb begin
        load_en        = do_start || do_step || do_restart;
        load_f         = frame_idx[7:0] + 8'd1;
        load_j         = '0;
        load_last_idx  = last_idx_q;
        load_last_keep = last_keep_q;
        load_bad       = bad_q;
        if (do_start) begin
            load_f         = 8'd0;
            load_last_idx  = start_last_idx;
            load_last_keep = start_last_keep;
            load_bad       = cfg_bad;
        end else if (do_step) begin
            load_f = frame_idx[7:0];
            load_j = beat_idx + LEN_WIDTH'(1);
        end else if (state == GAP) begin
            load_f = frame_idx[7:0];
        end
        load_is_last = (load_j == load_last_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx_q         <= '0;
            last_keep_q        <= '0;
            gap_q              <= '0;
            count_q            <= '0;
            bad_q              <= 1'b0;
            frame_idx          <= '0;
            beat_idx           <= '0;
            gap_cnt            <= '0;
            stop_seen          <= 1'b0;
            m_axis_tdata       <= '0;
            m_axis_tkeep       <= '0;
            m_axis_tvalid      <= 1'b0;
            m_axis_tlast       <= 1'b0;
            m_axis_tid         <= '0;
            m_axis_tdest       <= '0;
            m_axis_tuser       <= '0;
            status_frame_sent  <= 1'b0;
            status_frames_sent <= '0;
        end else begin
            status_frame_sent <= do_frame_end;

            if (do_start) begin
                last_idx_q  <= start_last_idx;
                last_keep_q <= start_last_keep;
                gap_q       <= cfg_gap;
                count_q     <= cfg_frame_count;
                bad_q       <= cfg_bad;
                m_axis_tid  <= cfg_id;
                m_axis_tdest <= cfg_dest;
                frame_idx   <= '0;
            end else if (do_frame_end) begin
                frame_idx <= frame_idx + 32'd1;
            end

            if (do_frame_end) begin
                status_frames_sent <= status_frames_sent + 32'd1;
            end

            // Stop stays armed until a frame boundary honours it.
            if (do_start || do_restart) begin
                stop_seen <= 1'b0;
            end else begin
                stop_seen <= stop_seen || stop;
            end

            if (do_frame_end) begin
                gap_cnt <= gap_q;
            end else if (do_gap_tick) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end

            if (load_en) begin
                m_axis_tdata  <= pattern(load_f, load_j);
                m_axis_tkeep  <= load_is_last ? load_last_keep : '1;
                m_axis_tlast  <= load_is_last;
                m_axis_tuser  <= load_is_last ? USER_WIDTH'(load_bad) : '0;
                m_axis_tvalid <= 1'b1;
                beat_idx      <= load_j;
            end else if (do_frame_end) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= '0;
            end
        end
    end

endmodule
